ibex_obi_ahb_arbiter: RTL and testbench
=======================================

# ibex_obi_ahb_arbiter

Sequencer and arbiter that shares the single AHB-Lite master port of the Ibex SoC between the core's instruction-fetch and data-access OBI requesters. It arbitrates, runs one non-pipelined AHB transfer at a time through address and data phases, honours HREADY wait states, and returns read data and error status to the granted requester. It sits between `ibex_core` and the system AHB fabric in `ibex_system`.

## Interface
- No parameters.
- HCLK  in  1  system clock; all logic on rising edge
- HRESET  in  1  synchronous reset, active-high
- instr_req_i  in  1  instruction fetch request
- instr_addr_i  in  32  fetch address (word aligned)
- instr_gnt_o  out  1  request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch bus error, valid with rvalid
- data_req_i  in  1  data request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data, lane-aligned
- data_gnt_o  out  1  request accepted
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  read data
- data_err_o  out  1  data bus error, valid with rvalid
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HSIZE  out  3  transfer size
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWRITE  out  1  write control
- HWDATA  out  32  write data
- HRDATA  in  32  read data
- HREADY  in  1  transfer done / stall
- HRESP  in  1  1 = ERROR

## Operation
- FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: if any req, pick winner, assert its gnt combinationally in that cycle, latch addr/we/be/wdata and owner; -> ADDR. No req: stay.
- Arbitration (default): data wins over instruction when both request.
- ADDR: HTRANS=NONSEQ, HADDR/HSIZE/HWRITE from latch. HREADY=1 -> DATA; HREADY=0 -> hold all address-phase outputs.
- DATA: HTRANS=IDLE, HWDATA=latched wdata (writes). HREADY=1 -> capture HRDATA and HRESP into response registers, -> RESP; HREADY=0 -> hold.
- RESP: one-cycle pulse of owner's rvalid with registered rdata/err; -> IDLE. gnt never asserted in RESP.
- Instruction transfers: HWRITE=0, HSIZE=3'b010, HADDR=addr with [1:0]=00.
- Data HSIZE/HADDR[1:0] from be: 4'b1111 -> 3'b010, 00; 4'b0011 -> 3'b001, 00; 4'b1100 -> 3'b001, 10; single bit n -> 3'b000, n. Any other pattern -> word, 00.
- HRESP=1 during DATA: err=1 with rvalid; rdata forced to 0.
- Non-owner's rvalid/err stay 0.

## Timing
- Reset: FSM=IDLE, HTRANS=00, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, all rvalid/err/rdata=0, RR pointer=instruction-last; gnt=0 while HRESET=1.
- Zero-wait latency: gnt cycle 0, NONSEQ cycle 1, data phase cycle 2, rvalid cycle 3. Each HREADY-low cycle adds one.
- Back-to-back: next gnt earliest in the cycle after RESP (4-cycle throughput).
- Requests arriving outside IDLE are held by the requester; no gnt until IDLE.
- Reset mid-transfer: transfer abandoned, no rvalid issued, HTRANS=IDLE next cycle.
- req dropping after gnt has no effect on the latched transfer.

## Configuration
- `IBEX_OBI_ARB_RR_EN` defined: round-robin arbitration; 1-bit pointer records last owner; on simultaneous requests the requester not granted last wins; pointer updates on every grant.
- Undefined: fixed priority, data over instruction; pointer logic absent.

## Test plan
- Instr read 0x0000_0080, HREADY=1, HRDATA=0x0000_0013 -> instr_gnt cycle 0, NONSEQ cycle 1, instr_rvalid cycle 3 with rdata 0x0000_0013, err=0.
- Data byte write addr 0x2000_0000, be=4'b0100, wdata=0x00AB_0000 -> HADDR=0x2000_0002, HSIZE=000, HWRITE=1, HWDATA=0x00AB_0000; data_rvalid, no instr_rvalid.
- Data read with HREADY low 2 cycles in ADDR and 3 in DATA -> outputs held stable, data_rvalid at cycle 8.
- Both requesting continuously -> default build: data granted every transaction; RR build: grants alternate data, instr, data, instr.
- HRESP=1 on data read -> data_rvalid=1, data_err=1, data_rdata=0.
- HRESET=1 during DATA state -> no rvalid, HTRANS=00, next request runs normally after release.

Source files
------------

// File: rtl/ibex_obi_ahb_arbiter.sv
// Shares one AHB-Lite master port between the Ibex instruction and data OBI requesters.
// Optional macro IBEX_OBI_ARB_RR_EN selects round-robin instead of data-first priority.
module ibex_obi_ahb_arbiter (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   // state  | meaning
   // S_IDLE | waiting for a request; grant issued combinationally here
   // S_ADDR | AHB address phase (NONSEQ), held while HREADY low
   // S_DATA | AHB data phase, response captured when HREADY high
   // S_RESP | one-cycle rvalid pulse to the owner
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_owner_data;
   logic [31:0] r_haddr, r_hwdata, r_rdata;
   logic [2:0]  r_hsize;
   logic        r_hwrite, r_err;
   logic        w_pick_data, w_grant, w_rvalid;
   logic [2:0]  w_dsize;
   logic [1:0]  w_doff;
   logic        w_unused;

   assign w_unused = ^{instr_addr_i[1:0], data_addr_i[1:0]};

`ifdef IBEX_OBI_ARB_RR_EN
   logic r_last_data;

   // On contention the requester that did not win last time goes first.
   assign w_pick_data = data_req_i & (~instr_req_i | ~r_last_data);

   always_ff @(posedge HCLK) begin
      if (HRESET) r_last_data <= 1'b0;
      else if (w_grant) r_last_data <= w_pick_data;
   end
`else
   assign w_pick_data = data_req_i;
`endif

   assign w_grant = (r_state == S_IDLE) & (instr_req_i | data_req_i) & ~HRESET;

   always_comb begin
      w_dsize = 3'b010;
      w_doff  = 2'b00;
      case (data_be_i)
         4'b0011: begin w_dsize = 3'b001; w_doff = 2'b00; end
         4'b1100: begin w_dsize = 3'b001; w_doff = 2'b10; end
         4'b0001: begin w_dsize = 3'b000; w_doff = 2'b00; end
         4'b0010: begin w_dsize = 3'b000; w_doff = 2'b01; end
         4'b0100: begin w_dsize = 3'b000; w_doff = 2'b10; end
         4'b1000: begin w_dsize = 3'b000; w_doff = 2'b11; end
         default: begin w_dsize = 3'b010; w_doff = 2'b00; end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      HTRANS      = 2'b00;
      case (r_state)
         S_IDLE: if (w_grant) w_state_nxt = S_ADDR;
         S_ADDR: begin
            HTRANS = 2'b10;
            if (HREADY) w_state_nxt = S_DATA;
         end
         S_DATA: if (HREADY) w_state_nxt = S_RESP;
         S_RESP: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state      <= S_IDLE;
         r_owner_data <= 1'b0;
         r_haddr      <= '0;
         r_hsize      <= '0;
         r_hwrite     <= 1'b0;
         r_hwdata     <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_owner_data <= w_pick_data;
            r_haddr      <= w_pick_data ? {data_addr_i[31:2], w_doff} : {instr_addr_i[31:2], 2'b00};
            r_hsize      <= w_pick_data ? w_dsize : 3'b010;
            r_hwrite     <= w_pick_data & data_we_i;
            r_hwdata     <= (w_pick_data & data_we_i) ? data_wdata_i : 32'h0;
         end
         // An errored transfer returns zero data so stale bus values never leak out.
         if (r_state == S_DATA && HREADY) begin
            r_rdata <= HRESP ? 32'h0 : HRDATA;
            r_err   <= HRESP;
         end
      end
   end

   assign w_rvalid       = (r_state == S_RESP);
   assign instr_gnt_o    = w_grant & ~w_pick_data;
   assign data_gnt_o     = w_grant & w_pick_data;
   assign instr_rvalid_o = w_rvalid & ~r_owner_data;
   assign data_rvalid_o  = w_rvalid & r_owner_data;
   assign instr_rdata_o  = instr_rvalid_o ? r_rdata : 32'h0;
   assign data_rdata_o   = data_rvalid_o ? r_rdata : 32'h0;
   assign instr_err_o    = instr_rvalid_o & r_err;
   assign data_err_o     = data_rvalid_o & r_err;

   assign HADDR  = r_haddr;
   assign HSIZE  = r_hsize;
   assign HWRITE = r_hwrite;
   assign HWDATA = r_hwdata;
   assign HBURST = 3'b000;

endmodule

// File: tb/tb_ibex_obi_ahb_arbiter.sv
// Randomised self-checking bench for ibex_obi_ahb_arbiter; transaction-level model of the
// arbitration and AHB phase timing. Honours IBEX_OBI_ARB_RR_EN like the design.
module tb_ibex_obi_ahb_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic        HWRITE, HREADY, HRESP;

   int errors = 0;
   int checks = 0;
   logic last_data;

   always #5 HCLK = ~HCLK;

   ibex_obi_ahb_arbiter dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   // {size, addr[1:0]} from byte enables, worked out from the lane count and lowest set lane.
   function automatic logic [4:0] exp_sz_off(input logic [3:0] be);
      int n;
      n = $countones(be);
      if (be == 4'b0011) return {3'b001, 2'b00};
      if (be == 4'b1100) return {3'b001, 2'b10};
      if (n == 1) begin
         for (int k = 0; k < 4; k++) if (be[k]) return {3'b000, 2'(k)};
      end
      return {3'b010, 2'b00};
   endfunction

   task automatic run_txn(input logic ireq, input logic dreq, input logic [31:0] iaddr,
                          input logic we, input logic [3:0] be, input logic [31:0] daddr,
                          input logic [31:0] wdata, input int nwa, input int nwd,
                          input logic [31:0] rdata, input logic resp, input logic drop,
                          output logic won_data);
      logic        wd;
      logic [4:0]  so;
      logic [31:0] e_addr;
      logic [2:0]  e_size;
      logic        e_write;
      int          total;
      if (dreq && ireq) begin
`ifdef IBEX_OBI_ARB_RR_EN
         wd = !last_data;
`else
         wd = 1'b1;
`endif
      end else begin
         wd = dreq;
      end
      last_data = wd;
      won_data  = wd;
      so      = exp_sz_off(be);
      e_addr  = wd ? {daddr[31:2], so[1:0]} : {iaddr[31:2], 2'b00};
      e_size  = wd ? so[4:2] : 3'b010;
      e_write = wd & we;
      total   = 4 + nwa + nwd;
      for (int c = 0; c < total; c++) begin
         @(negedge HCLK);
         if (c == 0) begin
            instr_req_i = ireq; instr_addr_i = iaddr;
            data_req_i = dreq; data_we_i = we; data_be_i = be;
            data_addr_i = daddr; data_wdata_i = wdata;
         end else if (drop) begin
            if (wd) begin
               data_req_i = 1'b0; data_addr_i = $urandom; data_wdata_i = $urandom;
               data_be_i = 4'($urandom); data_we_i = 1'($urandom);
            end else begin
               instr_req_i = 1'b0; instr_addr_i = $urandom;
            end
         end
         HRDATA = $urandom;
         HRESP  = 1'b0;
         if (c >= 1 && c <= 1 + nwa) HREADY = (c == 1 + nwa);
         else if (c >= 2 + nwa && c <= 2 + nwa + nwd) begin
            HREADY = (c == 2 + nwa + nwd);
            if (HREADY) begin HRDATA = rdata; HRESP = resp; end
         end else HREADY = 1'($urandom);
         #1;
         checks++;
         if (instr_gnt_o !== (c == 0 && !wd) || data_gnt_o !== (c == 0 && wd)) begin
            errors++;
            $display("FAIL gnt c=%0d got i=%b d=%b want winner_data=%b at c0 only", c, instr_gnt_o, data_gnt_o, wd);
         end
         checks++;
         if (HTRANS !== ((c >= 1 && c <= 1 + nwa) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL htrans c=%0d got %b", c, HTRANS);
         end
         if (c >= 1 && c <= 1 + nwa) begin
            checks++;
            if (HADDR !== e_addr || HSIZE !== e_size || HWRITE !== e_write || HBURST !== 3'b000) begin
               errors++;
               $display("FAIL addr_phase c=%0d got a=%h s=%b w=%b b=%b want a=%h s=%b w=%b", c,
                        HADDR, HSIZE, HWRITE, HBURST, e_addr, e_size, e_write);
            end
         end
         if (c >= 2 + nwa && c <= 2 + nwa + nwd && e_write) begin
            checks++;
            if (HWDATA !== wdata) begin
               errors++;
               $display("FAIL hwdata c=%0d got %h want %h", c, HWDATA, wdata);
            end
         end
         checks++;
         if (instr_rvalid_o !== (c == total - 1 && !wd) || data_rvalid_o !== (c == total - 1 && wd)) begin
            errors++;
            $display("FAIL rvalid c=%0d got i=%b d=%b want at c=%0d data=%b", c, instr_rvalid_o, data_rvalid_o, total - 1, wd);
         end
         if (c == total - 1) begin
            checks++;
            if (wd ? (data_rdata_o !== (resp ? 32'h0 : rdata) || data_err_o !== resp || instr_err_o !== 1'b0)
                   : (instr_rdata_o !== (resp ? 32'h0 : rdata) || instr_err_o !== resp || data_err_o !== 1'b0)) begin
               errors++;
               $display("FAIL resp got id=%h ie=%b dd=%h de=%b want data=%h err=%b owner_data=%b",
                        instr_rdata_o, instr_err_o, data_rdata_o, data_err_o, resp ? 32'h0 : rdata, resp, wd);
            end
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge HCLK);
         instr_req_i = 1'b0; data_req_i = 1'b0; HREADY = 1'($urandom);
         #1;
         checks++;
         if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || HTRANS !== 2'b00 ||
             instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle got gi=%b gd=%b t=%b rvi=%b rvd=%b", instr_gnt_o, data_gnt_o, HTRANS, instr_rvalid_o, data_rvalid_o);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge HCLK);
      HRESET = 1'b1; instr_req_i = 1'b1; data_req_i = 1'b1; HREADY = 1'b1;
      @(negedge HCLK);
      #1;
      checks++;
      if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt got i=%b d=%b want 0", instr_gnt_o, data_gnt_o);
      end
      checks++;
      if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HSIZE !== 3'b000 || HWRITE !== 1'b0 || HWDATA !== 32'h0 ||
          instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 ||
          data_rdata_o !== 32'h0 || instr_err_o !== 1'b0 || data_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got t=%b a=%h s=%b w=%b wd=%h", HTRANS, HADDR, HSIZE, HWRITE, HWDATA);
      end
      @(negedge HCLK);
      HRESET = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;
      last_data = 1'b0;
   endtask

   task automatic test_instr_read();
      logic w;
      run_txn(1'b1, 1'b0, 32'h0000_0080, 1'b0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h0000_0013, 1'b0, 1'b1, w);
      checks++;
      if (w !== 1'b0) begin errors++; $display("FAIL instr_read owner got data=%b want 0", w); end
   endtask

   task automatic test_byte_write();
      logic w;
      run_txn(1'b0, 1'b1, 32'h0, 1'b1, 4'b0100, 32'h2000_0000, 32'h00AB_0000, 0, 0, 32'h1234_5678, 1'b0, 1'b1, w);
   endtask

   task automatic test_wait_states();
      logic w;
      run_txn(1'b0, 1'b1, 32'h0, 1'b0, 4'b0011, 32'h3000_0010, 32'h0, 2, 3, 32'hCAFE_F00D, 1'b0, 1'b0, w);
   endtask

   task automatic test_error();
      logic w;
      run_txn(1'b0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h4000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b1, w);
      run_txn(1'b1, 1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h0, 1, 0, 32'h5555_AAAA, 1'b1, 1'b0, w);
   endtask

   task automatic test_back_to_back();
      logic w;
      logic [3:0] seq;
      test_reset();
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0, 4'hF, 32'h5000_0000 + 32'(i * 4), 32'h0,
                 0, 0, $urandom, 1'b0, 1'b0, w);
         seq[i] = w;
      end
      checks++;
`ifdef IBEX_OBI_ARB_RR_EN
      if (seq !== 4'b0101) begin errors++; $display("FAIL rr_sequence got %b want 0101 (lsb first)", seq); end
`else
      if (seq !== 4'b1111) begin errors++; $display("FAIL fixed_sequence got %b want 1111", seq); end
`endif
   endtask

   task automatic test_reset_mid();
      logic w;
      @(negedge HCLK);
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h6000_0000;
      instr_req_i = 1'b0; HREADY = 1'b1;
      #1;
      checks++;
      if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b want 1", data_gnt_o); end
      @(negedge HCLK);
      data_req_i = 1'b0;
      @(negedge HCLK);
      HREADY = 1'b0; HRESET = 1'b1;
      #1;
      checks++;
      if (HTRANS !== 2'b00 || data_rvalid_o !== 1'b0) begin
         errors++; $display("FAIL rstmid_data got t=%b rv=%b", HTRANS, data_rvalid_o);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge HCLK);
         HREADY = 1'b1; data_req_i = 1'b1;
         if (c == 2) begin HRESET = 1'b0; data_req_i = 1'b0; end
         #1;
         checks++;
         if (HTRANS !== 2'b00 || data_rvalid_o !== 1'b0 || instr_rvalid_o !== 1'b0 || data_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after c=%0d got t=%b rvd=%b rvi=%b gd=%b", c, HTRANS, data_rvalid_o, instr_rvalid_o, data_gnt_o);
         end
      end
      last_data = 1'b0;
      run_txn(1'b1, 1'b1, 32'h0000_0300, 1'b1, 4'b1000, 32'h6000_0008, 32'h7700_0000, 1, 1, 32'h0, 1'b0, 1'b1, w);
   endtask

   task automatic test_random();
      logic [3:0] bes [8];
      logic w;
      logic ir, dr;
      bes = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
      for (int i = 0; i < 150; i++) begin
         ir = 1'($urandom); dr = 1'($urandom);
         if (!ir && !dr) dr = 1'b1;
         run_txn(ir, dr, $urandom, 1'($urandom), bes[$urandom_range(0, 7)], $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0),
                 1'($urandom), w);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
   endtask

   initial begin
      HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
      last_data = 1'b0;
      repeat (2) @(negedge HCLK);
      test_reset();
      idle_cycles(2);
      test_instr_read();
      test_byte_write();
      test_wait_states();
      test_error();
      test_back_to_back();
      test_reset_mid();
      test_random();
      idle_cycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
